// File: rtl/cube_root_pkg.sv
// Shared widths, iteration constants and FSM encoding for cube, cube_root and mult_seq.
package cube_root_pkg;

   localparam int X_W        = 24;
   localparam int Y_W        = 8;
   localparam int MUL_W      = 16;
   localparam int B_W        = 18;
   localparam int ITER       = 8;
   localparam int S0         = 21;
   localparam int S_STEP     = 3;
   localparam int S_W        = 5;
   localparam int CNT_W      = 3;
   localparam int MUL_CYCLES = 8;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      LAUNCH,
      MWAIT,
      CHECK
   } state_t;

   // Trial subtrahend 3*y*(y+1) + 1, given p = y*(y+1).
   function automatic logic [B_W-1:0] cube_step_term(input logic [MUL_W-1:0] p);
      logic [B_W-1:0] pe;
      pe = B_W'(p);
      return (pe << 1) + pe + B_W'(1);
   endfunction

endpackage

// File: rtl/cube_root_mult_seq.sv
// Sequential 8x8 -> 16 shift-add multiplier; busy for exactly MUL_CYCLES cycles per product.
module mult_seq
   import cube_root_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [Y_W-1:0]   a_bi,
   input  logic [Y_W-1:0]   b_bi,
   output logic             busy_o,
   output logic [MUL_W-1:0] y_bo
);

   logic [MUL_W-1:0] a_sh;
   logic [MUL_W-1:0] acc;
   logic [MUL_W-1:0] acc_nxt;
   logic [Y_W-1:0]   b_sh;
   logic [CNT_W-1:0] cnt;

   assign acc_nxt = acc + (b_sh[0] ? a_sh : '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_sh   <= '0;
         b_sh   <= '0;
         acc    <= '0;
         cnt    <= '0;
         busy_o <= 1'b0;
         y_bo   <= '0;
      end else if (!busy_o) begin
         if (start_i) begin
            a_sh   <= MUL_W'(a_bi);
            b_sh   <= b_bi;
            acc    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
         end
      end else begin
         // One multiplier bit per cycle; the last cycle publishes the product.
         acc  <= acc_nxt;
         a_sh <= a_sh << 1;
         b_sh <= b_sh >> 1;
         cnt  <= cnt + CNT_W'(1);
         if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
            busy_o <= 1'b0;
            y_bo   <= acc_nxt;
         end
      end
   end

endmodule

// File: rtl/cube_root.sv
// Restoring digit-by-digit integer cube root: floor(cbrt(x)) of a 24-bit value, one root bit per 11 cycles.
module cube_root
   import cube_root_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           start_i,
   input  logic [X_W-1:0] x_bi,
   output logic           busy_o,
   output logic [Y_W-1:0] y_bo
);

   state_t           state;
   state_t           state_nxt;

   logic [X_W-1:0]   r;
   logic [Y_W-1:0]   y;
   logic [S_W-1:0]   s;
   logic [Y_W-1:0]   a_op;
   logic [Y_W-1:0]   b_op;
   logic [CNT_W-1:0] wait_cnt;

   logic             mul_start;
   logic             mul_busy;
   logic [MUL_W-1:0] mul_p;

   logic [B_W-1:0]   b_term;
   logic [X_W-1:0]   r_shr;
   logic [X_W-1:0]   b_shl;
   logic             take;
   logic [Y_W-1:0]   y_inc;

   mult_seq u_mult (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (mul_start),
      .a_bi    (a_op),
      .b_bi    (b_op),
      .busy_o  (mul_busy),
      .y_bo    (mul_p)
   );

   // Compare on the shifted remainder so nothing wider than X_W is needed.
   assign b_term = cube_step_term(mul_p);
   assign r_shr  = r >> s;
   assign b_shl  = X_W'(b_term) << s;
   assign take   = (r_shr >= X_W'(b_term));
   assign y_inc  = y + Y_W'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      mul_start = 1'b0;
      case (state)
         IDLE:    if (start_i) state_nxt = PREP;
         PREP:    state_nxt = LAUNCH;
         LAUNCH: begin
            mul_start = 1'b1;
            state_nxt = MWAIT;
         end
         // Leave on the same edge the multiplier drops busy and publishes p.
         MWAIT:   if (wait_cnt == '0) state_nxt = CHECK;
         CHECK:   state_nxt = (s == '0) ? IDLE : PREP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r        <= '0;
         y        <= '0;
         s        <= '0;
         a_op     <= '0;
         b_op     <= '0;
         wait_cnt <= '0;
         busy_o   <= 1'b0;
         y_bo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  r      <= x_bi;
                  y      <= '0;
                  s      <= S_W'(S0);
                  busy_o <= 1'b1;
               end
            end
            PREP: begin
               y    <= y << 1;
               a_op <= y << 1;
               b_op <= (y << 1) | Y_W'(1);
            end
            LAUNCH: begin
               wait_cnt <= CNT_W'(MUL_CYCLES - 1);
            end
            MWAIT: begin
               if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);
            end
            CHECK: begin
               if (take) begin
                  r <= r - b_shl;
                  y <= y_inc;
               end
               if (s == '0) begin
                  y_bo   <= take ? y_inc : y;
                  busy_o <= 1'b0;
               end else begin
                  s <= s - S_W'(S_STEP);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cube_root.sv
// Scoreboard bench for cube_root: stimulus pushes reference roots, a monitor pops them at each completion.
module tb_cube_root;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [23:0] x;
   logic        busy;
   logic [7:0]  y;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   cube_root dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .x_bi    (x),
      .busy_o  (busy),
      .y_bo    (y)
   );

   // Reference: largest k with k^3 <= v.
   function automatic int ref_cbrt(input longint v);
      longint k;
      k = 0;
      while ((k + 1) * (k + 1) * (k + 1) <= v) k++;
      return int'(k);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (busy && i < 300) begin
         tick();
         i++;
      end
      if (busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: busy still %0d after %0d cycles, expected 0", busy, i);
      end
   endtask

   task automatic run(input logic [23:0] v);
      wait_idle();
      x     = v;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_q.push_back(ref_cbrt(longint'(v)));
      wait_idle();
      tick();
   endtask

   // Monitor: measures busy length and checks the root on each falling busy.
   initial begin
      int  busy_len;
      logic prev_busy;
      int  e;
      busy_len  = 0;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_len  = 0;
            prev_busy = 1'b0;
         end else begin
            if (busy) begin
               busy_len++;
            end else if (prev_busy) begin
               check("latency", busy_len, 88);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_result: got root %0d, expected no completion", y);
               end else begin
                  e = exp_q.pop_front();
                  check("root", y, e);
               end
               busy_len = 0;
            end
            prev_busy = busy;
         end
      end
   end

   initial begin
      logic [23:0] v;
      int k;
      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      tick();
      tick();
      check("reset_busy", busy, 0);
      check("reset_y", y, 0);
      rst = 1'b0;
      repeat (5) tick();
      check("idle_busy", busy, 0);
      check("idle_y", y, 0);

      // Corner values
      run(24'd0);
      run(24'd1);
      run(24'd7);
      run(24'd8);
      run(24'd16777215);

      // Perfect cubes
      for (int c = 1; c <= 121; c += 12) run(24'(c * c * c));

      // Non-cubes around cube boundaries
      run(24'd999);
      run(24'd1000);
      run(24'd1330);
      run(24'd1331);
      run(24'd16581375);
      run(24'd16581374);

      // Random operands and random perfect cubes
      for (int i = 0; i < 12; i++) run(24'($urandom) & 24'hFFFFFF);
      for (int i = 0; i < 6; i++) begin
         k = int'($urandom_range(255, 0));
         run(24'(k * k * k));
      end

      // Start ignored while busy
      wait_idle();
      x     = 24'd1000;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_q.push_back(ref_cbrt(64'd1000));
      repeat (29) tick();
      x     = 24'd8;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle();
      repeat (5) tick();
      check("ignore_busy", busy, 0);
      check("ignore_y", y, 10);

      // Start held high: back-to-back runs, second operand changed mid-run
      v     = 24'd4913;
      x     = v;
      start = 1'b1;
      tick();
      exp_q.push_back(ref_cbrt(longint'(v)));
      v = 24'(($urandom & 24'hFFFFFF));
      exp_q.push_back(ref_cbrt(longint'(v)));
      x = v;
      wait_idle();
      tick();
      start = 1'b0;
      check("restart_busy", busy, 1);
      wait_idle();
      tick();

      // Reset mid-operation, then a clean run
      x     = 24'd1771561;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (39) tick();
      rst   = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_y", y, 0);
      rst = 1'b0;
      tick();
      check("abort_idle", busy, 0);
      run(24'd27);
      check("post_abort_y", y, 3);

      repeat (3) tick();
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cube_root.md
# cube_root

Sequential integer cube root: accepts a 24-bit unsigned value and returns floor(cbrt(x)) as an 8-bit result using the restoring digit-by-digit method, 1 result bit per iteration. Sits directly downstream of the `cube` block: consumes its 24-bit `y_bo` and closes the loop so that `cube_root(cube(x)) == x` can be checked in-system. Uses the same start/busy handshake as `cube`. Shares a sequential multiplier with it.

## Interface
Parameters: none. All widths are fixed; constants live in the shared header.

Ports:
- `clk_i`  in  1  — single clock; all state changes on the rising edge.
- `rst_i`  in  1  — synchronous, active-high reset.
- `start_i`  in  1  — request. Sampled only while idle.
- `x_bi`  in  24  — unsigned operand. Latched on an accepted start.
- `busy_o`  out  1  — high while a computation is in progress.
- `y_bo`  out  8  — result, floor(cbrt(x)). Valid while `busy_o` is 0 after a completed run.

## Operation
- Reset:
  - `busy_o` = 0, `y_bo` = 0.
  - FSM goes to IDLE.
  - Internal remainder `r`, root `y` and shift `s` are cleared.
  - Multiplier is reset.
- IDLE:
  - If `start_i` = 1: latch `r <= x_bi`, `y <= 0`, `s <= 21`, `busy_o <= 1`, then go to PREP.
  - Otherwise hold. `y_bo` keeps its last result.
- PREP (1 cycle): `y <= y << 1`. Load multiplier operands a = 2y, b = 2y + 1. Go to LAUNCH.
- LAUNCH (1 cycle): pulse the multiplier's `start_i` for 1 cycle. Go to MWAIT.
- MWAIT (8 cycles): wait for the multiplier result p = y·(y+1). Both operands are 8 bits; p ≤ 64770 (16 bits).
- CHECK (1 cycle):
  - Compute b = 3p + 1 (18 bits).
  - If (r >> s) ≥ b: `r <= r − (b << s)` and `y <= y + 1`.
  - The comparison is done on the shifted remainder, so no intermediate value wider than 24 bits is formed.
  - If s = 0: `y_bo <= final y`, `busy_o <= 0`, go to IDLE.
  - Otherwise: `s <= s − 3`, go to PREP.
- Exactly 8 iterations, with s = 21, 18, …, 0.
- Arithmetic is unsigned throughout. `r` never underflows, because subtraction happens only when the compare passes.
- Boundary rules:
  - `start_i` while busy: ignored. `x_bi` changes while busy: ignored.
  - `start_i` held high continuously: a new run begins on the first IDLE cycle after completion. `y_bo` shows the previous result for that one cycle only.
  - `rst_i` mid-operation: abort immediately. Outputs return to their reset values on the next edge, and the multiplier aborts too.
  - `rst_i` and `start_i` high together: reset wins and start is dropped.

## Timing
- Let edge E0 be the edge at which start is accepted.
  - `busy_o` is high from after E0 through E88.
  - At E88 both `busy_o <= 0` and `y_bo` are updated.
  - Total latency: 88 cycles.
- Per-iteration cost: 11 cycles (PREP 1 + LAUNCH 1 + MWAIT 8 + CHECK 1). 8 iterations give 88 cycles.
- Earliest restart: start sampled at E89 (1 idle cycle).
- Multiplier `mult_seq`, 8-bit × 8-bit → 16-bit, shift-add:
  - Latches its operands on the edge where `start_i` = 1 while idle.
  - Its `busy_o` is high for exactly 8 cycles.
  - Its `y_bo` is stable from the edge on which `busy_o` falls.
  - MWAIT leaves on that edge.

## Structure
- Shared header `cube_defs.vh`, common to `cube`, `cube_root` and `mult_seq`:
  - Widths: X_W = 24, Y_W = 8, MUL_W = 16.
  - Iteration count: ITER = 8, initial shift S0 = 21, shift step 3.
  - FSM state encodings: IDLE, PREP, LAUNCH, MWAIT, CHECK.
- One sub-module, `mult_seq` (sequential shift-add multiplier):
  - Port convention: `clk_i`, `rst_i`, `start_i`, `a_bi`, `b_bi`, `busy_o`, `y_bo`.
  - Instantiated once.
  - Same style as the multiplier inside `cube`, so it can be reused there.
- The remaining logic (FSM, `r`/`y`/`s` registers, compare/subtract datapath) stays in `cube_root`.

## Test plan
- Reset then idle: `rst_i` high 2 cycles → `busy_o` = 0, `y_bo` = 0; no activity without start.
- Corner values, each as one start pulse with `busy_o` checked high for exactly 88 cycles:
  - 0 → 0
  - 1 → 1
  - 7 → 1
  - 8 → 2
  - 16777215 → 255
- Perfect cubes fed from a `cube` instance, chained (`cube.y_bo` → `x_bi`, start on `cube.busy_o` falling), for x = 1, 13, 25, …, 121:
  - 2197 → 13
  - 1771561 → 121
  - every returned root equals the original x.
- Non-cubes: 999 → 9, 1000 → 10, 1330 → 10, 1331 → 11, 16581375 → 255, 16581374 → 254.
- Start ignored while busy: start x = 1000, then at cycle 30 pulse start with `x_bi` = 8 → single completion at E88 with result 10; no second run.
- Reset mid-op: start x = 1771561, assert `rst_i` at cycle 40 → `busy_o` = 0 and `y_bo` = 0 next edge; a following start with x = 27 returns 3 after 88 cycles.
